g_green_inv: RTL and testbench

Inverse camera-response lookup for the green channel. It holds a writable 64-entry copy of the forward green curve g(Z), which maps a 6-bit pixel to an 8-bit log-exposure value. For each 8-bit log value it returns the 6-bit pixel code. The search is a sequential 6-step binary search over the stored curve. It sits after HDR merge and tone mapping, converting merged log-radiance back to sensor pixel codes, and uses a valid/ready handshake on both sides.

---
 rtl/g_green_inv.sv | 125 ++++++++++++
 tb/tb_g_green_inv.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/g_green_inv.sv
`default_nettype none
// ============================================================================
// Module   : g_green_inv
// Purpose  : Inverse camera-response lookup for the green channel. Holds a
//            writable 2^PIX_W-entry copy of the forward curve g(Z) and, for
//            each LOG_W-bit log-exposure query, returns the largest pixel
//            code p with g[p] <= log_val using a PIX_W-step binary search.
// Ports    : clk, rst_n (async, active low), clk_en (global hold)
//            tbl_we/tbl_addr/tbl_wdata  - curve write port (IDLE only)
//            tbl_busy                   - search/result in progress
//            in_valid/in_ready/log_val  - query handshake
//            out_valid/out_ready/pixel  - result handshake
// Revision : 1.0  initial release
// ============================================================================
module g_green_inv #(
  parameter int PIX_W = 6,
  parameter int LOG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             tbl_we,
  input  logic [PIX_W-1:0] tbl_addr,
  input  logic [LOG_W-1:0] tbl_wdata,
  output logic             tbl_busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LOG_W-1:0] log_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] pixel
);

  localparam int c_DEPTH = 1 << PIX_W;
  localparam int c_BIT_W = (PIX_W > 1) ? $clog2(PIX_W) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t             r_state;
  logic [LOG_W-1:0]   r_tbl [c_DEPTH];
  logic [LOG_W-1:0]   r_key;
  logic [PIX_W-1:0]   r_acc;
  logic [c_BIT_W-1:0] r_bit;
  logic [PIX_W-1:0]   r_pixel;
  logic               r_out_valid;

  logic [PIX_W-1:0]   w_cand;
  logic               w_take;
  logic [PIX_W-1:0]   w_acc_next;
  logic               w_tbl_wr;

  // Trial code for this step: keep the bits already decided, set the current one.
  // Taking the candidate whenever g[cand] <= key makes flat runs resolve to
  // the highest index and a query below g[0] resolve to 0.
  assign w_cand     = r_acc | (PIX_W'(1) << r_bit);
  assign w_take     = (r_tbl[w_cand] <= r_key);
  assign w_acc_next = w_take ? w_cand : r_acc;

  assign w_tbl_wr   = clk_en && tbl_we && (r_state == ST_IDLE);

  assign in_ready   = (r_state == ST_IDLE);
  assign tbl_busy   = (r_state != ST_IDLE);
  assign out_valid  = r_out_valid;
  assign pixel      = r_pixel;

  // Curve storage. A write coinciding with query acceptance lands on the same
  // edge, so the first search step already sees it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_tbl[i] <= '0;
      end
    end else if (w_tbl_wr) begin
      r_tbl[tbl_addr] <= tbl_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_key       <= '0;
      r_acc       <= '0;
      r_bit       <= c_BIT_W'(PIX_W - 1);
      r_pixel     <= '0;
      r_out_valid <= 1'b0;
    end else if (clk_en) begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_key   <= log_val;
            r_acc   <= '0;
            r_bit   <= c_BIT_W'(PIX_W - 1);
            r_state <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          r_acc <= w_acc_next;
          if (r_bit == '0) begin
            r_pixel     <= w_acc_next;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_bit <= r_bit - c_BIT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_g_green_inv.sv
`default_nettype none
// ============================================================================
// Module   : tb_g_green_inv
// Purpose  : Self-checking bench for g_green_inv. Loads a green curve, runs a
//            table of directed queries with hand-computed results, then walks
//            backpressure, clk_en gating, write lockout and mid-search reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_g_green_inv;

  localparam int PIX_W = 6;
  localparam int LOG_W = 8;

  logic             clk;
  logic             rst_n;
  logic             clk_en;
  logic             tbl_we;
  logic [PIX_W-1:0] tbl_addr;
  logic [LOG_W-1:0] tbl_wdata;
  logic             tbl_busy;
  logic             in_valid;
  logic             in_ready;
  logic [LOG_W-1:0] log_val;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] pixel;

  int n_pass;
  int n_total;

  g_green_inv #(.PIX_W(PIX_W), .LOG_W(LOG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_en    (clk_en),
    .tbl_we    (tbl_we),
    .tbl_addr  (tbl_addr),
    .tbl_wdata (tbl_wdata),
    .tbl_busy  (tbl_busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .log_val   (log_val),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pixel     (pixel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [LOG_W-1:0] q;
    logic [PIX_W-1:0] exp_px;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Green curve: non-decreasing, with a flat run at 0x19/0x1A.
  function automatic logic [LOG_W-1:0] curve(input int p);
    if (p == 0)         return 8'h00;
    else if (p == 1)    return 8'h04;
    else if (p == 2)    return 8'h08;
    else if (p <= 'h18) return 8'(8'h0B + (p - 3));
    else if (p <= 'h1A) return 8'h28;
    else if (p <= 'h3E) return 8'(8'h29 + (p - 'h1B) / 2);
    else                return 8'h47;
  endfunction

  task automatic tbl_write(input int a, input logic [LOG_W-1:0] d);
    @(negedge clk);
    tbl_we    = 1'b1;
    tbl_addr  = PIX_W'(a);
    tbl_wdata = d;
    @(negedge clk);
    tbl_we    = 1'b0;
  endtask

  // Issue one query with out_ready high; returns result and edges from the
  // accept edge to out_valid. Ends at the negedge after the handshake edge.
  task automatic run_query(input logic [LOG_W-1:0] q, output int px, output int lat);
    int cnt;
    cnt = 0;
    @(negedge clk);
    while (!in_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    log_val   = q;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    px  = int'(pixel);
    lat = cnt;
    @(negedge clk);
  endtask

  initial begin
    int px;
    int lat;
    int cnt;
    logic bad;

    n_pass    = 0;
    n_total   = 0;
    rst_n     = 1'b0;
    clk_en    = 1'b1;
    tbl_we    = 1'b0;
    tbl_addr  = '0;
    tbl_wdata = '0;
    in_valid  = 1'b0;
    log_val   = '0;
    out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_tbl_busy", int'(tbl_busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_pixel", int'(pixel), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // All-zero table answers 63 for any query
    run_query(8'h00, px, lat);
    chk("zero_tbl_px", px, 'h3F);
    chk("zero_tbl_lat", lat, 6);

    for (int p = 0; p < 64; p++) tbl_write(p, curve(p));

    vecs[0]  = '{8'h08, 6'h02};
    vecs[1]  = '{8'h0A, 6'h02};
    vecs[2]  = '{8'h28, 6'h1A};
    vecs[3]  = '{8'h00, 6'h00};
    vecs[4]  = '{8'hFF, 6'h3F};
    vecs[5]  = '{8'h03, 6'h00};
    vecs[6]  = '{8'h05, 6'h01};
    vecs[7]  = '{8'h0C, 6'h04};
    vecs[8]  = '{8'h20, 6'h18};
    vecs[9]  = '{8'h29, 6'h1C};
    vecs[10] = '{8'h46, 6'h3E};

    foreach (vecs[i]) begin
      run_query(vecs[i].q, px, lat);
      chk($sformatf("vec%0d_px", i), px, int'(vecs[i].exp_px));
      chk($sformatf("vec%0d_lat", i), lat, 6);
      chk($sformatf("vec%0d_ready", i), int'(in_ready), 1);
      chk($sformatf("vec%0d_ovalid_clr", i), int'(out_valid), 0);
    end

    // Backpressure: out_ready low, a second query held on in_valid
    @(negedge clk);
    log_val   = 8'h0B;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    log_val   = 8'h00;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("bp_lat", cnt, 6);
    for (int i = 0; i < 10; i++) begin
      chk("bp_ovalid", int'(out_valid), 1);
      chk("bp_pixel", int'(pixel), 'h03);
      chk("bp_in_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_ovalid", int'(out_valid), 0);
    chk("bp_hs_in_ready", int'(in_ready), 1);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid || !in_ready) bad = 1'b1;
    end
    chk("bp_no_second", int'(bad), 0);

    // clk_en gating: disabled writes must not land
    @(negedge clk);
    clk_en    = 1'b0;
    tbl_we    = 1'b1;
    tbl_addr  = 6'h3F;
    tbl_wdata = 8'hFF;
    @(negedge clk);
    tbl_addr  = 6'h3E;
    @(negedge clk);
    tbl_we    = 1'b0;
    clk_en    = 1'b1;
    log_val   = 8'h47;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      if (k == 12) chk("ce_not_yet", int'(out_valid), 0);
      if (k == 6) chk("ce_busy", int'(tbl_busy), 1);
      clk_en = (k % 2 == 0);
    end
    @(negedge clk);
    chk("ce_ovalid", int'(out_valid), 1);
    chk("ce_pixel", int'(pixel), 'h3F);
    clk_en    = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("ce_frz_ovalid", int'(out_valid), 1);
    chk("ce_frz_pixel", int'(pixel), 'h3F);
    chk("ce_frz_ready", int'(in_ready), 0);
    clk_en = 1'b1;
    @(negedge clk);
    chk("ce_hs_ovalid", int'(out_valid), 0);
    chk("ce_hs_ready", int'(in_ready), 1);

    // Write lockout during SEARCH
    @(negedge clk);
    log_val   = 8'h08;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    tbl_we    = 1'b1;
    tbl_addr  = 6'h02;
    tbl_wdata = 8'hFF;
    @(negedge clk);
    tbl_we    = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("lock_search_px", int'(pixel), 'h02);
    @(negedge clk);
    run_query(8'h08, px, lat);
    chk("lock_after_px", px, 'h02);
    tbl_write(2, 8'hFF);
    run_query(8'h08, px, lat);
    chk("idle_write_px", px, 'h01);

    // Reset three cycles into a search
    @(negedge clk);
    log_val  = 8'h30;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", int'(tbl_busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_ovalid", int'(out_valid), 0);
    chk("mr_in_ready", int'(in_ready), 1);
    chk("mr_pixel", int'(pixel), 0);
    chk("mr_busy", int'(tbl_busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) bad = 1'b1;
    end
    chk("mr_no_stale", int'(bad), 0);
    run_query(8'h10, px, lat);
    chk("mr_cleared_px", px, 'h3F);
    chk("mr_cleared_lat", lat, 6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
